// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: shared miss-fill engine for the I- and D-caches.
// Arbitrates icache_miss/dcache_miss onto one pipelined memory read port,
// streams each returned word into the selected cache (fill_*), then
// writes its tag. Ports: clk, rst (async, active-high); icache_miss/addr,
// dcache_miss/addr in; mem_rd_req/mem_addr out, mem_data_valid/mem_data in;
// fill_sel/addr/data/data_write/tag_write out; icache_stall, dcache_stall,
// busy out. Define FILL_RR_EN for round-robin arbitration; otherwise the
// D-cache has fixed priority.
module cache_fill_ctrl #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic              fill_sel,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       fill_data,
  output logic              fill_data_write,
  output logic              fill_tag_write,
  output logic              icache_stall,
  output logic              dcache_stall,
  output logic              busy
);

  localparam int BW = ADDR_W - 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_TAG  = 2'd2;

  localparam logic [3:0] NWORDS =
    4'(WORDS_PER_BLOCK);
  localparam logic [2:0] LAST =
    3'(WORDS_PER_BLOCK - 1);

  logic [1:0]    state;
  logic [BW-1:0] base;
  logic [3:0]    issue_cnt;
  logic [2:0]    rcv_cnt;
  logic          sel_q;

  logic in_fill;
  logic in_tag;
  logic any_miss;
  logic grant_d;
  logic unused_lo;

  // byte offset bits are recomputed from the counters
  assign unused_lo =
    ^{icache_addr[3:0], dcache_addr[3:0]};

  assign in_fill  = (state == S_FILL);
  assign in_tag   = (state == S_TAG);
  assign any_miss = icache_miss | dcache_miss;

`ifdef FILL_RR_EN
  // rr_ptr set: D was served last, so I wins a tie
  logic rr_ptr;

  assign grant_d =
    dcache_miss & (~icache_miss | ~rr_ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == S_IDLE && any_miss) begin
      rr_ptr <= grant_d;
    end
  end
`else
  assign grant_d = dcache_miss;
`endif

  assign busy     = (state != S_IDLE);
  assign fill_sel = sel_q;

  assign mem_rd_req =
    in_fill & (issue_cnt < NWORDS);
  assign mem_addr =
    {base, issue_cnt[2:0], 1'b0};

  assign fill_data_write =
    in_fill & mem_data_valid;
  assign fill_data =
    fill_data_write ? mem_data : 16'h0;
  assign fill_addr =
    fill_data_write ? {base, rcv_cnt, 1'b0}
                    : {base, 4'h0};
  assign fill_tag_write = in_tag;

  assign icache_stall =
    icache_miss | (busy & ~sel_q);
  assign dcache_stall =
    dcache_miss | (busy & sel_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      base      <= '0;
      issue_cnt <= 4'd0;
      rcv_cnt   <= 3'd0;
      sel_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_miss) begin
            state     <= S_FILL;
            base      <= grant_d
                       ? dcache_addr[ADDR_W-1:4]
                       : icache_addr[ADDR_W-1:4];
            sel_q     <= grant_d;
            issue_cnt <= 4'd0;
            rcv_cnt   <= 3'd0;
          end
        end
        S_FILL: begin
          if (mem_rd_req) begin
            issue_cnt <= issue_cnt + 4'd1;
          end
          if (mem_data_valid) begin
            rcv_cnt <= rcv_cnt + 3'd1;
            if (rcv_cnt == LAST) begin
              state <= S_TAG;
            end
          end
        end
        S_TAG: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed + randomized bench for cache_fill_ctrl.
// Transaction-level fill model and in-order latency memory model.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_addr = 16'h0;
  logic        dcache_miss = 1'b0;
  logic [15:0] dcache_addr = 16'h0;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic        fill_sel;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        fill_data_write;
  logic        fill_tag_write;
  logic        icache_stall;
  logic        dcache_stall;
  logic        busy;

  cache_fill_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .icache_miss     (icache_miss),
    .icache_addr     (icache_addr),
    .dcache_miss     (dcache_miss),
    .dcache_addr     (dcache_addr),
    .mem_rd_req      (mem_rd_req),
    .mem_addr        (mem_addr),
    .mem_data_valid  (mem_data_valid),
    .mem_data        (mem_data),
    .fill_sel        (fill_sel),
    .fill_addr       (fill_addr),
    .fill_data       (fill_data),
    .fill_data_write (fill_data_write),
    .fill_tag_write  (fill_tag_write),
    .icache_stall    (icache_stall),
    .dcache_stall    (dcache_stall),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } rd_t;

  rd_t mq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  lat = 4;
  bit  gap_mode = 0;
  int  hold_cnt = 0;
  bit  spur = 0;
  bit  rst_pending = 1;
  int  i_left = 0;
  int  d_left = 0;

  // transaction model of the current fill
  bit          m_act = 0;
  int          m_g = 0;
  bit          m_sel = 0;
  logic [11:0] m_base = 12'h0;
  int          m_nw = 0;
  int          m_tag = -1;
  bit          m_last_d = 0;

  // observations
  bit prev_busy = 0;
  int wr_obs = 0;
  int first_wr = -1;
  int late_valids = 0;
  bit grants_obs[$];
  int rise_cycs[$];
  int fall_cycs[$];
  int tag_cycs[$];
  bit exp3[4];

  function automatic logic [15:0] memf(
    input logic [15:0] a
  );
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(
    input string       t,
    input logic [15:0] o,
    input logic [15:0] e
  );
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h want %h",
             t, o, e);
    end
  endtask

  task automatic update_model();
    bit gd;
    if (rst) return;
    if (m_act && m_tag == cyc) begin
      m_act = 0;
      if (m_sel) begin
        if (d_left > 0) d_left--;
        if (d_left == 0) dcache_miss = 0;
        else dcache_addr = dcache_addr + 16'h0110;
      end else begin
        if (i_left > 0) i_left--;
        if (i_left == 0) icache_miss = 0;
        else icache_addr = icache_addr + 16'h0220;
      end
    end else if (m_act) begin
      if (mem_data_valid) begin
        m_nw++;
        if (m_nw == 8) m_tag = cyc + 1;
      end
    end else if (icache_miss || dcache_miss) begin
`ifdef FILL_RR_EN
      gd = dcache_miss &&
           !(icache_miss && m_last_d);
`else
      gd = dcache_miss;
`endif
      m_act    = 1;
      m_g      = cyc;
      m_sel    = gd;
      m_base   = gd ? dcache_addr[15:4]
                    : icache_addr[15:4];
      m_nw     = 0;
      m_tag    = -1;
      m_last_d = gd;
    end
  endtask

  task automatic checks_now();
    logic [15:0] bo;
    logic [15:0] ea;
    int k;
    if (mem_data_valid &&
        (rst || !m_act || m_tag == cyc))
      late_valids++;
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_req", mem_rd_req, 0);
      check("rst_maddr", mem_addr, 0);
      check("rst_wr", fill_data_write, 0);
      check("rst_tag", fill_tag_write, 0);
      check("rst_sel", fill_sel, 0);
      check("rst_faddr", fill_addr, 0);
      check("rst_fdata", fill_data, 0);
      check("rst_istall", icache_stall,
            icache_miss);
      check("rst_dstall", dcache_stall,
            dcache_miss);
      m_act = 0; m_base = 0; m_sel = 0;
      m_last_d = 0; m_tag = -1;
      prev_busy = 0; wr_obs = 0;
      return;
    end
    bo = {m_base, 4'h0};
    check("busy", busy, m_act);
    check("fill_sel", fill_sel, m_sel);
    check("istall", icache_stall,
          icache_miss | (m_act & ~m_sel));
    check("dstall", dcache_stall,
          dcache_miss | (m_act & m_sel));
    if (!m_act) begin
      check("idle_req", mem_rd_req, 0);
      check("idle_wr", fill_data_write, 0);
      check("idle_tag", fill_tag_write, 0);
      check("idle_faddr", fill_addr, bo);
    end else if (m_tag == cyc) begin
      check("tag", fill_tag_write, 1);
      check("tag_wr", fill_data_write, 0);
      check("tag_req", mem_rd_req, 0);
      check("tag_faddr", fill_addr, bo);
    end else begin
      k = cyc - m_g;
      check("req", mem_rd_req, 16'(k <= 8));
      if (k <= 8)
        check("mem_addr", mem_addr,
              bo + 16'(2 * (k - 1)));
      check("fill_tag", fill_tag_write, 0);
      check("wr", fill_data_write,
            mem_data_valid);
      if (mem_data_valid) begin
        ea = bo + 16'(2 * m_nw);
        check("fill_addr", fill_addr, ea);
        check("fill_data", fill_data,
              memf(ea));
      end
    end
    if (mem_rd_req)
      mq.push_back('{mem_addr, cyc + lat});
    if (busy && !prev_busy) begin
      grants_obs.push_back(fill_sel);
      rise_cycs.push_back(cyc);
    end
    if (!busy && prev_busy)
      fall_cycs.push_back(cyc);
    prev_busy = busy;
    if (fill_data_write) begin
      wr_obs++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (fill_tag_write) begin
      tag_cycs.push_back(cyc);
      check("writes_per_fill",
            16'(wr_obs), 8);
      wr_obs = 0;
    end
  endtask

  task automatic tick();
    update_model();
    @(posedge clk);
    cyc++;
    #1;
    rst = rst_pending;
    mem_data_valid = 0;
    mem_data = 16'($urandom);
    if (hold_cnt > 0) begin
      hold_cnt--;
    end else if (mq.size() > 0 &&
                 mq[0].due <= cyc) begin
      mem_data_valid = 1;
      mem_data = memf(mq[0].addr);
      void'(mq.pop_front());
      hold_cnt = gap_mode
               ? int'($urandom_range(3, 0)) : 0;
    end else if (spur) begin
      mem_data_valid = 1;
      mem_data = 16'hBEEF;
      spur = 0;
    end
    #1;
    checks_now();
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((m_act || icache_miss ||
            dcache_miss) && n < 500) begin
      tick();
      n++;
    end
    check("idle_timeout", 16'(n < 500), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_timeout", 16'(n < 100), 1);
  endtask

  task automatic do_reset();
    icache_miss = 0;
    dcache_miss = 0;
    i_left = 0;
    d_left = 0;
    hold_cnt = 0;
    rst_pending = 1;
    tick();
    tick();
    rst_pending = 0;
    tick();
  endtask

  task automatic clear_obs();
    grants_obs.delete();
    rise_cycs.delete();
    fall_cycs.delete();
    tag_cycs.delete();
    first_wr = -1;
  endtask

  initial begin
    int t0;
    int n;
    bit [1:0] who;

`ifdef FILL_RR_EN
    exp3[0] = 1; exp3[1] = 0;
    exp3[2] = 1; exp3[3] = 1;
`else
    exp3[0] = 1; exp3[1] = 1;
    exp3[2] = 1; exp3[3] = 0;
`endif

    // reset state
    do_reset();

    // single D miss, L=4
    lat = 4;
    clear_obs();
    dcache_addr = 16'h1234;
    dcache_miss = 1;
    d_left = 1;
    t0 = cyc;
    wait_idle();
    check("t1_first_wr", 16'(first_wr - t0), 5);
    check("t1_ntag", 16'(tag_cycs.size()), 1);
    if (tag_cycs.size() > 0)
      check("t1_tag_cyc",
            16'(tag_cycs[0] - t0), 13);
    check("t1_nfall", 16'(fall_cycs.size()), 1);
    if (fall_cycs.size() > 0)
      check("t1_idle_cyc",
            16'(fall_cycs[0] - t0), 14);

    // simultaneous misses
    do_reset();
    lat = 3;
    clear_obs();
    icache_addr = 16'h0040;
    dcache_addr = 16'h8800;
    icache_miss = 1;
    dcache_miss = 1;
    i_left = 1;
    d_left = 1;
    wait_idle();
    check("t2_ngrant",
          16'(grants_obs.size()), 2);
    if (grants_obs.size() == 2) begin
      check("t2_first", grants_obs[0], 1);
      check("t2_second", grants_obs[1], 0);
    end
    if (rise_cycs.size() == 2 &&
        tag_cycs.size() > 0)
      check("t2_restart",
            16'(rise_cycs[1] - tag_cycs[0]), 2);

    // repeated D misses against a pending I miss
    do_reset();
    lat = 2;
    clear_obs();
    icache_addr = 16'h0300;
    dcache_addr = 16'h4400;
    icache_miss = 1;
    dcache_miss = 1;
    i_left = 1;
    d_left = 3;
    wait_idle();
    check("t3_ngrant",
          16'(grants_obs.size()), 4);
    if (grants_obs.size() == 4)
      for (int i = 0; i < 4; i++)
        check($sformatf("t3_grant%0d", i),
              grants_obs[i], exp3[i]);

    // reset after three returned words
    do_reset();
    lat = 5;
    clear_obs();
    dcache_addr = 16'h2468;
    dcache_miss = 1;
    d_left = 1;
    n = 0;
    while (wr_obs < 3 && n < 50) begin
      tick();
      n++;
    end
    check("t4_wr3_timeout", 16'(n < 50), 1);
    dcache_miss = 0;
    d_left = 0;
    late_valids = 0;
    rst_pending = 1;
    tick();
    rst_pending = 0;
    drain();
    repeat (3) tick();
    check("t4_late", 16'(late_valids), 5);
    clear_obs();
    dcache_miss = 1;
    d_left = 1;
    wait_idle();
    check("t4_refill", 16'(tag_cycs.size()), 1);

    // irregular memory, random traffic
    gap_mode = 1;
    for (int it = 0; it < 8; it++) begin
      lat = int'($urandom_range(6, 1));
      who = 2'($urandom_range(3, 1));
      icache_addr = 16'($urandom);
      dcache_addr = 16'($urandom);
      clear_obs();
      if (who[0]) begin
        icache_miss = 1;
        i_left = 1;
      end
      if (who[1]) begin
        dcache_miss = 1;
        d_left = 1;
      end
      wait_idle();
      check($sformatf("t5_fills%0d", it),
            16'(tag_cycs.size()),
            16'(who[0] + who[1]));
    end

    // spurious valid while idle
    gap_mode = 0;
    clear_obs();
    spur = 1;
    repeat (4) tick();
    check("t6_spur_writes", 16'(first_wr), 16'hFFFF);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller for the direct-mapped caches: it arbitrates between the instruction-cache and data-cache miss lines, which share one memory read port. It fetches the missing 16-byte block as `WORDS_PER_BLOCK` pipelined word reads, streams each returned word into the cache data array, and then writes the tag. It sits between the two `cache` instances and main memory, and drives their `data_write`, `tag_write` and fill address.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, default 8: words per cache block. Must be a power of two. Word offset is `address[3:1]`.
- `ADDR_W`, default 16: byte address width.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `icache_miss`, in, 1: I-cache miss from its tag compare.
- `icache_addr`, in, 16: byte address causing the I-cache miss.
- `dcache_miss`, in, 1: D-cache miss.
- `dcache_addr`, in, 16: byte address causing the D-cache miss.
- `mem_rd_req`, out, 1: one word read request per asserted cycle.
- `mem_addr`, out, 16: read address, word aligned.
- `mem_data_valid`, in, 1: returned word valid. Returns arrive in request order.
- `mem_data`, in, 16: returned word.
- `fill_sel`, out, 1: cache being filled (0 = I-cache, 1 = D-cache).
- `fill_addr`, out, 16: address presented to the selected cache during a fill.
- `fill_data`, out, 16: data to the selected cache's `data_in`.
- `fill_data_write`, out, 1: `data_write` strobe for the selected cache.
- `fill_tag_write`, out, 1: `tag_write` strobe for the selected cache.
- `icache_stall`, out, 1: pipeline stall for fetch.
- `dcache_stall`, out, 1: pipeline stall for memory stage.
- `busy`, out, 1: the FSM is not in IDLE.

## Operation
- States: IDLE, FILL, TAG.
- **IDLE**
  - If neither miss is asserted, stay in IDLE.
  - Otherwise grant one requester.
  - On the edge, latch `base = addr[15:4]` of the granted requester, set `fill_sel`, clear `issue_cnt` (4 bits) and `rcv_cnt` (3 bits), and go to FILL.
- **FILL**
  - While `issue_cnt < WORDS_PER_BLOCK`: `mem_rd_req=1`, `mem_addr = {base, issue_cnt[2:0], 1'b0}`, and `issue_cnt` increments.
  - On each `mem_data_valid`: `fill_data_write=1`, `fill_data=mem_data`, `fill_addr = {base, rcv_cnt, 1'b0}`, and `rcv_cnt` increments (wraps 7 -> 0).
  - A valid with `rcv_cnt==7` moves the FSM to TAG.
- **TAG**
  - For one cycle: `fill_tag_write=1` and `fill_addr = {base, 4'b0}`.
  - Then return to IDLE.
- Outside FILL, `fill_addr` equals `{base, 4'b0}`.
- `mem_data_valid` in IDLE or TAG is ignored: no write and no counter change.
- A miss line that deasserts mid-fill does not abort the fill. The block completes.
- Stalls:
  - `icache_stall = icache_miss | (busy & ~fill_sel)`.
  - `dcache_stall = dcache_miss | (busy & fill_sel)`.
- Arbitration on simultaneous misses follows the Configuration section. A single pending miss is always granted.

## Timing
- Reset values:
  - State is IDLE.
  - `base`, `issue_cnt`, `rcv_cnt`, `fill_sel` and the round-robin pointer are 0.
  - All strobes (`mem_rd_req`, `fill_data_write`, `fill_tag_write`) and `busy` are 0.
- Assertion of `rst` mid-fill aborts immediately to IDLE. Requests already in flight are dropped: their later valids arrive in IDLE and are ignored.
- Miss seen in IDLE at cycle N:
  - `mem_rd_req` is high for cycles N+1 through N+8.
  - With memory latency L, valids arrive at N+1+L through N+8+L.
  - TAG occurs at N+9+L.
  - IDLE is reached at N+10+L, and a new grant can be made in that cycle.
- Read requests and data writes overlap. Memory stalls (gaps in valid) only extend FILL.
- All fill outputs are combinational from the registered state and `mem_data_valid`.

## Configuration
- `FILL_RR_EN` defined:
  - Round-robin between requesters.
  - On simultaneous misses, grant the requester not served last.
  - The pointer updates on every grant.
  - The first grant after reset goes to the D-cache.
- `FILL_RR_EN` undefined: fixed priority, with the D-cache always winning simultaneous misses.

## Test plan
- **Single D miss:** `dcache_addr=0x1234`, L=4, miss at N.
  - Requests to 0x1230, 0x1232, … 0x123E at N+1..N+8.
  - Eight `fill_data_write` pulses at N+5..N+12 with `fill_addr` 0x1230..0x123E.
  - `fill_tag_write` at N+13 with `fill_addr=0x1230`, `fill_sel=1`.
  - `busy` low at N+14.
- **Simultaneous misses:** I at 0x0040, D at 0x8800.
  - D is filled first.
  - `icache_stall` stays high throughout.
  - The I fill starts in the IDLE cycle after the D TAG, with requests 0x0040..0x004E.
- **Repeated misses:** D misses back-to-back while I also misses.
  - `FILL_RR_EN` defined: grants alternate D, I, D.
  - `FILL_RR_EN` undefined: D is granted until D goes idle.
- **Reset mid-fill:** assert `rst` after 3 returned words.
  - All outputs are 0 immediately.
  - The 5 late valids cause no `fill_data_write`.
  - A re-raised miss restarts from word 0.
- **Irregular memory:**
  - Valid pulses separated by random 0-3 cycle gaps: exactly 8 writes, in order, and TAG follows the 8th.
  - A spurious valid in IDLE produces no write.
